input_holder: RTL and testbench

//  Receive end of the chip's byte I/O interface; the output path is the transmit end.
//  - Captures a plaintext/key byte from the input pins using a four-phase valid/ack handshake with the chip user.
//  - Holds the byte and presents it to the stream cipher core through a valid/ready handshake.
//  - Acknowledges the user only after the core has consumed the byte.

---
 rtl/input_holder.sv | 196 +++++++++++++++++++
 tb/tb_input_holder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_holder.sv
// -----------------------------------------------------------------------------
// input_holder
//
// Receive end of the chip's byte I/O interface.
//
// The chip user drives a byte onto data_in and raises input_valid (four-phase
// handshake, asynchronous to clk). The strobe is synchronized, the byte is
// captured into a holding register and offered to the stream cipher core on a
// valid/ready interface. Only after the core has consumed the byte is the user
// acknowledged with in_ack. The user then drops input_valid and the block
// lowers in_ack, completing the four-phase cycle.
//
// If the user keeps input_valid high for too long after being acknowledged,
// the sticky protocol_error flag is raised. The flag is informational only and
// never stalls the datapath.
//
// Parameters
//   DATA_WIDTH      width of the byte bus
//   SYNC_STAGES     flops in the input_valid synchronizer (must be >= 2)
//   TIMEOUT_CYCLES  cycles allowed in RELEASE with the strobe still high before
//                   protocol_error is raised (must be >= 1)
//   COUNT_WIDTH     width of the accepted-byte counter
//
// Ports
//   clk             in   system clock
//   rst             in   asynchronous reset, active-high
//   data_in         in   byte from the pins, stable while input_valid is high
//   input_valid     in   user strobe, asynchronous to clk
//   core_ready      in   cipher core can take a byte this cycle
//   err_clear       in   synchronous clear of protocol_error
//   byte_out        out  captured byte presented to the core
//   byte_valid      out  byte_out holds an unconsumed byte
//   in_ack          out  four-phase acknowledge to the user
//   byte_count      out  bytes handed to the core, modulo 2^COUNT_WIDTH
//   protocol_error  out  sticky: user did not drop input_valid in time
//
// Latencies (all outputs registered)
//   pin rise  -> byte_valid : SYNC_STAGES + 1 cycles
//   transfer  -> in_ack     : 1 cycle
//   pin fall  -> in_ack low : SYNC_STAGES + 1 cycles
// -----------------------------------------------------------------------------
module input_holder #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned COUNT_WIDTH    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  data_in,
  input  logic                   input_valid,
  input  logic                   core_ready,
  input  logic                   err_clear,
  output logic [DATA_WIDTH-1:0]  byte_out,
  output logic                   byte_valid,
  output logic                   in_ack,
  output logic [COUNT_WIDTH-1:0] byte_count,
  output logic                   protocol_error
);

  // Timeout counter only needs to reach TIMEOUT_CYCLES, where it saturates.
  localparam int unsigned          TMR_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0]     TMR_MAX = TMR_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,  // waiting for a synchronized strobe rise
    PRESENT = 2'd1,  // byte offered to the core
    RELEASE = 2'd2   // core took the byte, ack held until strobe drops
  } state_e;

  // ---------------------------------------------------------------------------
  // Strobe synchronizer
  // ---------------------------------------------------------------------------
  // NOTE: input_valid is asynchronous to clk; only the last stage of this chain
  // may feed logic, otherwise a metastable value can reach several flops and
  // be resolved differently in each.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   valid_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the values from before the edge, independent of statement order.
      sync_q <= {sync_q[SYNC_STAGES-2:0], input_valid};
    end
  end

  assign valid_s = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Handshake FSM and datapath registers
  // ---------------------------------------------------------------------------
  state_e                 state_q,      state_d;
  logic [DATA_WIDTH-1:0]  byte_q,       byte_d;
  logic                   byte_valid_q, byte_valid_d;
  logic                   in_ack_q,     in_ack_d;
  logic [COUNT_WIDTH-1:0] count_q,      count_d;
  logic [TMR_W-1:0]       tmr_q,        tmr_d;
  logic                   err_q,        err_d;
  logic                   err_set;

  // NOTE: the byte holding register is a single word, not a memory array, so
  // resetting it is cheap and guarantees no stale byte survives a reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      byte_q       <= '0;
      byte_valid_q <= 1'b0;
      in_ack_q     <= 1'b0;
      count_q      <= '0;
      tmr_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_q       <= byte_d;
      byte_valid_q <= byte_valid_d;
      in_ack_q     <= in_ack_d;
      count_q      <= count_d;
      tmr_q        <= tmr_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default first; a path that left
    // one unassigned would infer a latch.
    state_d      = state_q;
    byte_d       = byte_q;
    byte_valid_d = byte_valid_q;
    in_ack_d     = in_ack_q;
    count_d      = count_q;
    tmr_d        = tmr_q;
    err_set      = 1'b0;

    unique case (state_q)
      IDLE: begin
        byte_valid_d = 1'b0;
        in_ack_d     = 1'b0;
        tmr_d        = '0;
        // Entry into IDLE always happens with valid_s low, so a strobe held
        // high across a handshake can never be captured a second time.
        if (valid_s) begin
          byte_d       = data_in;
          byte_valid_d = 1'b1;
          state_d      = PRESENT;
        end
      end

      PRESENT: begin
        // The strobe is deliberately ignored here: once captured, the byte is
        // delivered even if the user drops input_valid early.
        if (byte_valid_q && core_ready) begin
          count_d      = count_q + COUNT_WIDTH'(1);
          byte_valid_d = 1'b0;
          in_ack_d     = 1'b1;
          tmr_d        = '0;
          state_d      = RELEASE;
        end
      end

      RELEASE: begin
        if (!valid_s) begin
          in_ack_d = 1'b0;
          tmr_d    = '0;
          state_d  = IDLE;
        end else begin
          tmr_d = (tmr_q == TMR_MAX) ? tmr_q : tmr_q + TMR_W'(1);
          // Keeps asserting while saturated so a clear cannot win against a
          // user that is still holding the strobe high.
          if (tmr_d == TMR_MAX) begin
            err_set = 1'b1;
          end
        end
      end

      default: begin
        state_d      = IDLE;
        byte_valid_d = 1'b0;
        in_ack_d     = 1'b0;
        tmr_d        = '0;
      end
    endcase

    // Set has priority over clear.
    err_d = err_set | (err_q & ~err_clear);
  end

  assign byte_out       = byte_q;
  assign byte_valid     = byte_valid_q;
  assign in_ack         = in_ack_q;
  assign byte_count     = count_q;
  assign protocol_error = err_q;

endmodule

// File: tb/tb_input_holder.sv
// -----------------------------------------------------------------------------
// tb_input_holder
//
// Drives complete four-phase handshakes into input_holder and predicts every
// output from the block's latency and protocol rules: a handshake is described
// by its data byte, how long the core stalls, whether the user drops the strobe
// early, and how long the user keeps the strobe high after the ack.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_input_holder;

  localparam int DW   = 8;
  localparam int SYNC = 2;
  localparam int TO   = 4;
  localparam int CW   = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] data_in;
  logic          input_valid;
  logic          core_ready;
  logic          err_clear;
  logic [DW-1:0] byte_out;
  logic          byte_valid;
  logic          in_ack;
  logic [CW-1:0] byte_count;
  logic          protocol_error;

  int vectors     = 0;
  int miscompares = 0;

  // Expected state carried between handshakes.
  logic [CW-1:0] exp_count;
  logic          exp_err;

  input_holder #(
    .DATA_WIDTH    (DW),
    .SYNC_STAGES   (SYNC),
    .TIMEOUT_CYCLES(TO),
    .COUNT_WIDTH   (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .data_in       (data_in),
    .input_valid   (input_valid),
    .core_ready    (core_ready),
    .err_clear     (err_clear),
    .byte_out      (byte_out),
    .byte_valid    (byte_valid),
    .in_ack        (in_ack),
    .byte_count    (byte_count),
    .protocol_error(protocol_error)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full handshake, starting and ending at a falling edge in IDLE with a
  // low synchronized strobe.
  //   wait_k : cycles the core holds core_ready low while the byte is offered
  //   early  : user drops input_valid right after byte_valid appears
  //            (wait_k >= 2 so the drop is fully synchronized by the transfer)
  //   hold_d : cycles after the ack before the user drops input_valid
  //   clr    : err_clear held high throughout the release phase
  task automatic handshake(input logic [DW-1:0] d, input int wait_k, input bit early,
                           input int hold_d, input bit clr);
    logic err_before;
    logic set_by_j;
    data_in     = d;
    input_valid = 1'b1;
    for (int i = 1; i <= SYNC; i++) begin
      step();
      chk1("sync_wait_valid", byte_valid, 1'b0);
      chk1("sync_wait_ack", in_ack, 1'b0);
    end
    step();
    chk1("capture_valid", byte_valid, 1'b1);
    chk8("capture_data", byte_out, d);
    chk1("capture_ack", in_ack, 1'b0);
    data_in = 8'($urandom);
    if (early) input_valid = 1'b0;
    for (int i = 0; i < wait_k; i++) begin
      core_ready = 1'b0;
      step();
      chk1("stall_valid", byte_valid, 1'b1);
      chk8("stall_data", byte_out, d);
      chk1("stall_ack", in_ack, 1'b0);
      chk8("stall_count", byte_count, exp_count);
    end
    core_ready = 1'b1;
    step();
    exp_count = exp_count + 8'd1;
    chk1("xfer_valid", byte_valid, 1'b0);
    chk1("xfer_ack", in_ack, 1'b1);
    chk8("xfer_count", byte_count, exp_count);
    chk1("xfer_err", protocol_error, exp_err);
    err_before = exp_err;
    core_ready = 1'($urandom);
    if (early) begin
      step();
      chk1("early_ack_drop", in_ack, 1'b0);
      chk1("early_valid", byte_valid, 1'b0);
      chk1("early_err", protocol_error, exp_err);
    end else begin
      err_clear = clr;
      // The strobe is seen high by hold_d + SYNC release cycles; the flag is
      // raised on the TO-th of them if there are that many.
      for (int j = 1; j <= hold_d + SYNC + 1; j++) begin
        if (j == hold_d + 1) input_valid = 1'b0;
        core_ready = 1'($urandom);
        step();
        set_by_j = (j >= TO) && (j <= hold_d + SYNC);
        exp_err  = clr ? set_by_j : (err_before | ((TO <= hold_d + SYNC) && (j >= TO)));
        chk1("release_ack", in_ack, j <= hold_d + SYNC);
        chk1("release_valid", byte_valid, 1'b0);
        chk8("release_count", byte_count, exp_count);
        chk1("release_err", protocol_error, exp_err);
      end
      err_clear = 1'b0;
    end
  endtask

  task automatic idle_gap(input int n);
    input_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      core_ready = 1'($urandom);
      data_in    = 8'($urandom);
      step();
      chk1("idle_valid", byte_valid, 1'b0);
      chk1("idle_ack", in_ack, 1'b0);
      chk8("idle_count", byte_count, exp_count);
      chk1("idle_err", protocol_error, exp_err);
    end
  endtask

  task automatic clear_err();
    err_clear = 1'b1;
    step();
    exp_err = 1'b0;
    chk1("err_clear", protocol_error, exp_err);
    err_clear = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    data_in     = '0;
    input_valid = 1'b0;
    core_ready  = 1'b0;
    err_clear   = 1'b0;
    exp_count   = '0;
    exp_err     = 1'b0;

    // Reset state
    step();
    step();
    chk1("reset_valid", byte_valid, 1'b0);
    chk8("reset_data", byte_out, 8'h00);
    chk1("reset_ack", in_ack, 1'b0);
    chk8("reset_count", byte_count, 8'h00);
    chk1("reset_err", protocol_error, 1'b0);
    rst = 1'b0;
    idle_gap(2);

    // Basic handshake, immediate core_ready, prompt strobe drop
    core_ready = 1'b1;
    handshake(8'hA5, 0, 1'b0, 0, 1'b0);
    idle_gap(1);

    // Core stalls for 10 cycles
    handshake(8'h3C, 10, 1'b0, 0, 1'b0);
    idle_gap(1);

    // Strobe held high through several core_ready pulses: one byte only,
    // and the long hold raises the flag
    handshake(8'h5A, 0, 1'b0, 8, 1'b0);
    idle_gap(2);
    clear_err();

    // Timeout boundary: TO-1 high release cycles stays clean, TO sets the flag
    handshake(8'h81, 1, 1'b0, TO - SYNC - 1, 1'b0);
    chk1("timeout_below", protocol_error, 1'b0);
    handshake(8'hC3, 1, 1'b0, TO - SYNC, 1'b0);
    chk1("timeout_at", protocol_error, 1'b1);
    idle_gap(3);
    clear_err();

    // err_clear held during a timeout: set wins
    handshake(8'h96, 0, 1'b0, 5, 1'b1);
    idle_gap(1);
    clear_err();

    // Early strobe drop while the core stalls: byte still delivered
    handshake(8'h11, 3, 1'b1, 0, 1'b0);
    idle_gap(1);

    // Randomized handshakes
    for (int n = 0; n < 150; n++) begin
      int  wk;
      bit  early;
      early = ($urandom_range(0, 4) == 0);
      wk    = $urandom_range(0, 5);
      if (early && wk < 2) wk = 2;
      handshake(8'($urandom), wk, early, $urandom_range(0, 5), $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) clear_err();
      idle_gap($urandom_range(0, 2));
    end

    // Counter wrap
    for (int n = 0; n < 256 && exp_count != 8'hFF; n++) begin
      handshake(8'($urandom), 0, 1'b0, 0, 1'b0);
    end
    chk8("count_preload", byte_count, 8'hFF);
    handshake(8'hE7, 0, 1'b0, 0, 1'b0);
    chk8("count_wrap", byte_count, 8'h00);

    // Leave a nonzero count and a set flag, then reset mid-PRESENT
    handshake(8'h24, 0, 1'b0, 3, 1'b0);
    chk1("pre_reset_err", protocol_error, 1'b1);
    data_in     = 8'h77;
    input_valid = 1'b1;
    core_ready  = 1'b0;
    for (int i = 0; i <= SYNC; i++) step();
    chk1("pre_reset_valid", byte_valid, 1'b1);
    chk8("pre_reset_data", byte_out, 8'h77);
    #1 rst = 1'b1;
    #1;
    chk1("midrst_valid", byte_valid, 1'b0);
    chk8("midrst_data", byte_out, 8'h00);
    chk1("midrst_ack", in_ack, 1'b0);
    chk8("midrst_count", byte_count, 8'h00);
    chk1("midrst_err", protocol_error, 1'b0);
    exp_count = '0;
    exp_err   = 1'b0;
    step();
    rst = 1'b0;
    // Strobe still high at reset release: a fresh capture follows
    handshake(8'h42, 2, 1'b0, 1, 1'b0);
    idle_gap(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
